// File: rtl/data_sram_responder.sv
// data_sram_responder: memory-side responder for the CPU data SRAM port.
// Word-organised store with byte-lane write enables, returning read data
// after WAIT_CYCLES wait states (latency WAIT_CYCLES+1). stall_req is high
// while a request is accepted but its response is not yet valid.
//
// Handshake: a request is taken whenever data_sram_en=1 and the FSM is in
// IDLE or RESP. In BUSY data_sram_en is ignored because the initiator is
// stalled and holds its request. resp_valid is a one-cycle pulse in RESP,
// and data_sram_rdata/err belong to the request that just committed.
//
// Optional macro DSRAM_ALIGN_CHECK_EN: stores whose byte enables do not
// match the address alignment are suppressed and flagged with err.
module data_sram_responder #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        stall_req,
  output logic        resp_valid,
  output logic        err,
  output logic [1:0]  dbg_state_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0] CNT_LOAD = ZERO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  // Latched request
  logic [DEPTH_LOG2-1:0] req_idx_q;
  logic [3:0]            req_wen_q;
  logic [31:0]           req_wdata_q;
  logic                  req_ill_q;

  // Storage and read register
  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;
  logic        err_q;

  // Incoming request decode
  logic                  accept;
  logic [DEPTH_LOG2-1:0] in_idx;
  logic                  in_illegal;
  logic [3:0]            in_wen_eff;

  // Operands used on the commit edge
  logic                  commit;
  logic [DEPTH_LOG2-1:0] c_idx;
  logic [3:0]            c_wen;
  logic [31:0]           c_wdata;
  logic                  c_ill;

  // Address bits above the word index (and the byte offset when alignment
  // is not checked) do not select anything.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{data_sram_addr[31:DEPTH_LOG2+2], data_sram_addr[1:0]};

  assign accept = data_sram_en && ((state_q == IDLE) || (state_q == RESP));
  assign in_idx = data_sram_addr[DEPTH_LOG2+1:2];

`ifdef DSRAM_ALIGN_CHECK_EN
  // Classify the incoming store: legal only if the lanes match the byte offset
  always_comb begin
    in_illegal = 1'b0;
    unique case (data_sram_wen)
      4'b0000: in_illegal = 1'b0;
      4'b1111: in_illegal = (data_sram_addr[1:0] != 2'b00);
      4'b0011: in_illegal = (data_sram_addr[1:0] != 2'b00);
      4'b1100: in_illegal = (data_sram_addr[1:0] != 2'b10);
      4'b0001: in_illegal = (data_sram_addr[1:0] != 2'b00);
      4'b0010: in_illegal = (data_sram_addr[1:0] != 2'b01);
      4'b0100: in_illegal = (data_sram_addr[1:0] != 2'b10);
      4'b1000: in_illegal = (data_sram_addr[1:0] != 2'b11);
      default: in_illegal = 1'b1;
    endcase
  end
`else
  assign in_illegal = 1'b0;
`endif

  // An illegal store is turned into a no-write request at accept time
  assign in_wen_eff = in_illegal ? 4'b0000 : data_sram_wen;

  // With zero wait states the accept edge is also the commit edge, so the
  // incoming request is used directly instead of the latched copy.
  assign commit  = ZERO_WAIT ? accept : ((state_q == BUSY) && (cnt_q == 4'd0));
  assign c_idx   = ZERO_WAIT ? in_idx          : req_idx_q;
  assign c_wen   = ZERO_WAIT ? in_wen_eff      : req_wen_q;
  assign c_wdata = ZERO_WAIT ? data_sram_wdata : req_wdata_q;
  assign c_ill   = ZERO_WAIT ? in_illegal      : req_ill_q;

  // FSM state and wait counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: accept in IDLE/RESP, count down in BUSY
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, RESP: begin
        if (accept) begin
          if (ZERO_WAIT) begin
            state_d = RESP;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_LOAD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Moore outputs decoded from the state
  always_comb begin
    stall_req   = 1'b0;
    resp_valid  = 1'b0;
    err         = 1'b0;
    dbg_state_o = state_q;
    unique case (state_q)
      BUSY:    stall_req  = 1'b1;
      RESP:    resp_valid = 1'b1;
      default: ;
    endcase
`ifdef DSRAM_ALIGN_CHECK_EN
    err = (state_q == RESP) && err_q;
`endif
  end

  // Capture the request on accept so it survives the wait states
  always_ff @(posedge clk) begin
    if (rst) begin
      req_idx_q   <= '0;
      req_wen_q   <= 4'b0000;
      req_wdata_q <= 32'd0;
      req_ill_q   <= 1'b0;
    end else if (accept) begin
      req_idx_q   <= in_idx;
      req_wen_q   <= in_wen_eff;
      req_wdata_q <= data_sram_wdata;
      req_ill_q   <= in_illegal;
    end
  end

  // Read data and error flag update on the commit edge, held otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else if (commit) begin
      rdata_q <= mem_q[c_idx];
      err_q   <= c_ill;
    end
  end

  // Lane-masked store on the commit edge; the read above sees the old word
  always_ff @(posedge clk) begin
    if (!rst && commit) begin
      for (int i = 0; i < 4; i++) begin
        if (c_wen[i]) begin
          mem_q[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
        end
      end
    end
  end

  assign data_sram_rdata = rdata_q;

endmodule
